// File: rtl/jpeg_pixel_packer.sv
// rtl/jpeg_pixel_packer.sv - packs RGB pixels into OUT_W-bit words behind a small output FIFO
// Optional GREY8 luma path is built only when JPEG_PIXEL_PACKER_GREY_EN is defined.
module jpeg_pixel_packer #(
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               inport_valid_i,
  input  logic [15:0]        inport_width_i,
  input  logic [15:0]        inport_height_i,
  input  logic [15:0]        inport_pixel_x_i,
  input  logic [15:0]        inport_pixel_y_i,
  input  logic [7:0]         inport_pixel_r_i,
  input  logic [7:0]         inport_pixel_g_i,
  input  logic [7:0]         inport_pixel_b_i,
  input  logic [1:0]         cfg_mode_i,
  input  logic               outport_accept_i,
  output logic               inport_accept_o,
  output logic               outport_valid_o,
  output logic [OUT_W-1:0]   outport_data_o,
  output logic [OUT_W/8-1:0] outport_strb_o,
  output logic               outport_last_o,
  output logic               idle_o
);
  localparam int NB = OUT_W / 8;
  localparam int PW = $clog2(NB + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t           state_q;
  logic [1:0]       mode_q;
  logic [OUT_W-1:0] acc_q;
  logic [PW-1:0]    pos_q;
  logic [OUT_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [NB-1:0]    fifo_strb_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             accept_q;

  logic [1:0]       mode_sel;
  logic [PW-1:0]    pix_bytes, fill;
  logic [31:0]      pix_word;
  logic [OUT_W-1:0] pix_ext, acc_d;
  logic [NB-1:0]    strb_d;
  logic             frame_end, pix_fire, push, pop;

`ifdef JPEG_PIXEL_PACKER_GREY_EN
  logic [15:0] luma_sum;
  logic [7:0]  luma;
  assign luma_sum = 16'd77 * {8'd0, inport_pixel_r_i} + 16'd150 * {8'd0, inport_pixel_g_i}
                  + 16'd29 * {8'd0, inport_pixel_b_i};
  assign luma = 8'(luma_sum >> 8);
`endif

  // The first pixel of a frame uses the live mode; the rest use the latched one.
  always_comb begin
    mode_sel  = (state_q == S_IDLE) ? cfg_mode_i : mode_q;
    pix_bytes = PW'(4);
    pix_word  = {8'h00, inport_pixel_r_i, inport_pixel_g_i, inport_pixel_b_i};
    case (mode_sel)
      2'd1: begin
        pix_bytes = PW'(2);
        pix_word  = {16'h0000, inport_pixel_r_i[7:3], inport_pixel_g_i[7:2], inport_pixel_b_i[7:3]};
      end
`ifdef JPEG_PIXEL_PACKER_GREY_EN
      2'd2: begin
        pix_bytes = PW'(1);
        pix_word  = {24'h000000, luma};
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    pix_ext       = '0;
    pix_ext[31:0] = pix_word;
    acc_d         = acc_q | (pix_ext << {pos_q, 3'b000});
    fill          = pos_q + pix_bytes;
    for (int i = 0; i < NB; i++) begin
      strb_d[i] = (PW'(i) < fill);
    end
  end

  assign frame_end = (inport_pixel_x_i == inport_width_i - 16'd1) &&
                     (inport_pixel_y_i == inport_height_i - 16'd1);
  assign pix_fire  = inport_valid_i && accept_q;
  assign push      = pix_fire && (frame_end || (fill == PW'(NB)));
  assign pop       = outport_valid_o && outport_accept_i;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'd0;
      acc_q       <= '0;
      pos_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      accept_q    <= 1'b0;
      fifo_last_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_strb_q[i] <= '0;
      end
    end else begin
      if (pix_fire) begin
        if (state_q == S_IDLE) begin
          mode_q <= cfg_mode_i;
          if (!frame_end) state_q <= S_ACTIVE;
        end else if (frame_end) begin
          state_q <= S_IDLE;
        end
        if (push) begin
          fifo_data_q[wr_ptr_q] <= acc_d;
          fifo_strb_q[wr_ptr_q] <= strb_d;
          fifo_last_q[wr_ptr_q] <= frame_end;
          wr_ptr_q              <= wr_ptr_q + AW'(1);
          acc_q                 <= '0;
          pos_q                 <= '0;
        end else begin
          acc_q <= acc_d;
          pos_q <= fill;
        end
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_d;
      accept_q <= (count_d != CW'(FIFO_DEPTH));
    end
  end

  assign inport_accept_o = accept_q;
  assign outport_valid_o = (count_q != '0);
  assign outport_data_o  = fifo_data_q[rd_ptr_q];
  assign outport_strb_o  = fifo_strb_q[rd_ptr_q];
  assign outport_last_o  = fifo_last_q[rd_ptr_q];
  assign idle_o          = (state_q == S_IDLE) && (count_q == '0) && (pos_q == '0);
endmodule

// File: tb/tb_jpeg_pixel_packer.sv
// tb/tb_jpeg_pixel_packer.sv - self-checking bench for jpeg_pixel_packer
// Expectations follow JPEG_PIXEL_PACKER_GREY_EN the same way as the design build.
module tb_jpeg_pixel_packer;
  localparam int DEPTH = 4;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  s;
    logic        l;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n, pv, sink, use64, pv64;
  logic [15:0] px, py, pw, ph;
  logic [7:0]  pr, pg, pb;
  logic [1:0]  cfg;

  logic        acc32, v32, l32, idle32;
  logic [31:0] d32;
  logic [3:0]  s32;
  logic        acc64, v64, l64, idle64;
  logic [63:0] d64;
  logic [7:0]  s64;

  int checks = 0, failures = 0, fired = 0;
  word_t exp_q[$], log32[$], log64[$];
  int    bq[$];
  int    fm = 0;
  bit    in_frame = 0, accept_exp = 0;
  word_t mon_w, mon64_w;

  always #5 clk = ~clk;
  assign pv64 = pv & use64;

  jpeg_pixel_packer #(.OUT_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_n), .inport_valid_i(pv),
    .inport_width_i(pw), .inport_height_i(ph), .inport_pixel_x_i(px), .inport_pixel_y_i(py),
    .inport_pixel_r_i(pr), .inport_pixel_g_i(pg), .inport_pixel_b_i(pb),
    .cfg_mode_i(cfg), .outport_accept_i(sink), .inport_accept_o(acc32),
    .outport_valid_o(v32), .outport_data_o(d32), .outport_strb_o(s32),
    .outport_last_o(l32), .idle_o(idle32));

  jpeg_pixel_packer #(.OUT_W(64), .FIFO_DEPTH(DEPTH)) dut64 (
    .clk_i(clk), .rst_i(rst_n), .inport_valid_i(pv64),
    .inport_width_i(pw), .inport_height_i(ph), .inport_pixel_x_i(px), .inport_pixel_y_i(py),
    .inport_pixel_r_i(pr), .inport_pixel_g_i(pg), .inport_pixel_b_i(pb),
    .cfg_mode_i(cfg), .outport_accept_i(1'b1), .inport_accept_o(acc64),
    .outport_valid_o(v64), .outport_data_o(d64), .outport_strb_o(s64),
    .outport_last_o(l64), .idle_o(idle64));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic emit(input logic last);
    word_t w;
    w.d = '0; w.s = '0; w.l = last;
    for (int i = 0; i < bq.size(); i++) begin
      w.d = w.d | (64'(bq[i]) << (8 * i));
      w.s[i] = 1'b1;
    end
    exp_q.push_back(w);
    bq.delete();
  endtask

  // Byte-list model: a pixel becomes its byte sequence, words are cut at 4 bytes or frame end.
  task automatic model_pixel();
    int v;
    if (!in_frame) begin
      fm = int'(cfg);
      if (fm == 3) fm = 0;
`ifndef JPEG_PIXEL_PACKER_GREY_EN
      if (fm == 2) fm = 0;
`endif
      in_frame = 1;
    end
    if (fm == 1) begin
      v = (int'(pr) / 8) * 2048 + (int'(pg) / 4) * 32 + int'(pb) / 8;
      bq.push_back(v % 256);
      bq.push_back(v / 256);
    end else if (fm == 2) begin
      bq.push_back((77 * int'(pr) + 150 * int'(pg) + 29 * int'(pb)) / 256);
    end else begin
      bq.push_back(int'(pb)); bq.push_back(int'(pg)); bq.push_back(int'(pr)); bq.push_back(0);
    end
    if (int'(px) == int'(pw) - 1 && int'(py) == int'(ph) - 1) begin
      emit(1'b1);
      in_frame = 0;
    end else if (bq.size() == 4) begin
      emit(1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); bq.delete(); in_frame = 0; accept_exp = 0;
    end else begin
      chk("valid", v32, exp_q.size() != 0);
      chk("in_accept", acc32, accept_exp);
      chk("idle", idle32, !in_frame && exp_q.size() == 0 && bq.size() == 0);
      if (v32 && exp_q.size() != 0) begin
        chk("data", d32, exp_q[0].d);
        chk("strb", s32, exp_q[0].s);
        chk("last", l32, exp_q[0].l);
      end
      if (v32 && sink) begin
        mon_w.d = 64'(d32); mon_w.s = 8'(s32); mon_w.l = l32;
        log32.push_back(mon_w);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (pv && acc32) begin
        fired++;
        model_pixel();
      end
      accept_exp = (exp_q.size() != DEPTH);
    end
  end

  always @(negedge clk) begin
    if (rst_n && v64) begin
      mon64_w.d = d64; mon64_w.s = s64; mon64_w.l = l64;
      log64.push_back(mon64_w);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int y, input int w, input int h,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int n = 0;
    px = 16'(x); py = 16'(y); pw = 16'(w); ph = 16'(h);
    pr = r; pg = g; pb = b; pv = 1'b1;
    while (!acc32 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("px_accept_timeout", acc32, 1);
    tick();
    pv = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!idle32 && n < 500) begin
      tick();
      n++;
    end
    chk("idle_reached", idle32, 1);
  endtask

  task automatic expect_word(input string name, input int idx, input logic [63:0] d,
                             input logic [7:0] s, input logic l);
    chk({name, "_present"}, log32.size() > idx, 1);
    if (log32.size() > idx) begin
      chk({name, "_data"}, log32[idx].d, d);
      chk({name, "_strb"}, log32[idx].s, s);
      chk({name, "_last"}, log32[idx].l, l);
    end
  endtask

  logic [31:0] r038_exp [6] = '{32'h00101010, 32'h00202020, 32'h00303030,
                                32'h00404040, 32'h00505050, 32'h00606060};

  initial begin
    int base, f0;
    rst_n = 1'b0; pv = 1'b0; use64 = 1'b0; sink = 1'b1; cfg = 2'd0;
    px = '0; py = '0; pw = 16'd1; ph = 16'd1; pr = '0; pg = '0; pb = '0;
    tick(); tick();
    chk("rst_in_accept", acc32, 0);
    chk("rst_valid", v32, 0);
    chk("rst_data", d32, 0);
    chk("rst_strb", s32, 0);
    chk("rst_last", l32, 0);
    chk("rst_idle", idle32, 1);
    rst_n = 1'b1;
    tick(); tick();
    chk("accept_after_reset", acc32, 1);

    // 2x1 xRGB frame
    base = log32.size(); cfg = 2'd0;
    send(0, 0, 2, 1, 8'h11, 8'h22, 8'h33);
    send(1, 0, 2, 1, 8'h44, 8'h55, 8'h66);
    wait_idle();
    expect_word("r035_w0", base, 64'h00112233, 8'hF, 1'b0);
    expect_word("r035_w1", base + 1, 64'h00445566, 8'hF, 1'b1);

    // 3x1 RGB565 frame on the 64-bit instance
    use64 = 1'b1; cfg = 2'd1;
    for (int i = 0; i < 3; i++) send(i, 0, 3, 1, 8'hFF, 8'hFF, 8'hFF);
    use64 = 1'b0;
    wait_idle(); tick(); tick();
    chk("r036_count", log64.size(), 1);
    if (log64.size() > 0) begin
      chk("r036_data", log64[0].d, 64'h0000FFFFFFFFFFFF);
      chk("r036_strb", log64[0].s, 8'h3F);
      chk("r036_last", log64[0].l, 1);
    end

    // 5x1 GREY8 frame
    base = log32.size(); cfg = 2'd2;
    for (int i = 0; i < 5; i++) send(i, 0, 5, 1, 8'hFF, 8'hFF, 8'hFF);
    wait_idle();
`ifdef JPEG_PIXEL_PACKER_GREY_EN
    expect_word("r037_w0", base, 64'hFFFFFFFF, 8'hF, 1'b0);
    expect_word("r037_w1", base + 1, 64'h000000FF, 8'h1, 1'b1);
`else
    for (int i = 0; i < 5; i++) expect_word("r037_w", base + i, 64'h00FFFFFF, 8'hF, i == 4);
`endif

    // FIFO backpressure: 6 xRGB pixels with the sink stalled
    cfg = 2'd0; sink = 1'b0; base = log32.size(); f0 = fired;
    fork
      for (int i = 0; i < 6; i++) send(i, 0, 6, 1, 8'(16 * (i + 1)), 8'(16 * (i + 1)), 8'(16 * (i + 1)));
      begin
        repeat (20) tick();
        chk("r038_accepted", fired - f0, 4);
        chk("r038_in_accept", acc32, 0);
        chk("r038_valid", v32, 1);
        sink = 1'b1;
      end
    join
    wait_idle();
    for (int i = 0; i < 6; i++) expect_word("r038_w", base + i, 64'(r038_exp[i]), 8'hF, i == 5);

    // mode change mid-frame is ignored until the next frame
    base = log32.size(); cfg = 2'd1;
    send(0, 0, 4, 1, 8'hFF, 8'h00, 8'hFF);
    send(1, 0, 4, 1, 8'hFF, 8'h00, 8'hFF);
    cfg = 2'd0;
    send(2, 0, 4, 1, 8'hFF, 8'h00, 8'hFF);
    send(3, 0, 4, 1, 8'hFF, 8'h00, 8'hFF);
    wait_idle();
    send(0, 0, 1, 1, 8'h10, 8'h20, 8'h30);
    wait_idle();
    expect_word("r039_w0", base, 64'hF81FF81F, 8'hF, 1'b0);
    expect_word("r039_w1", base + 1, 64'hF81FF81F, 8'hF, 1'b1);
    expect_word("r039_w2", base + 2, 64'h00102030, 8'hF, 1'b1);

    // reset mid-frame discards everything
    sink = 1'b0; cfg = 2'd0;
    for (int i = 0; i < 3; i++) send(i, 0, 8, 1, 8'(i + 1), 8'(i + 1), 8'(i + 1));
    tick();
    chk("r040_pre_valid", v32, 1);
    rst_n = 1'b0;
    #1;
    chk("r040_in_accept", acc32, 0);
    chk("r040_valid", v32, 0);
    chk("r040_data", d32, 0);
    chk("r040_strb", s32, 0);
    chk("r040_last", l32, 0);
    chk("r040_idle", idle32, 1);
    tick();
    rst_n = 1'b1; sink = 1'b1;
    tick(); tick();
    base = log32.size(); cfg = 2'd1;
    send(0, 0, 2, 1, 8'h00, 8'hFF, 8'h00);
    send(1, 0, 2, 1, 8'h00, 8'hFF, 8'h00);
    wait_idle();
    expect_word("r040_w0", base, 64'h07E007E0, 8'hF, 1'b1);
    chk("r040_no_stale", log32.size(), base + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
